// File: rtl/seg_pkg.sv
// Shared constants for the seg_scan display stage: segment patterns,
// digit-slot encoding and the idle ("off") bus values for both polarities.
package seg_pkg;

  // Active-high gfedcba patterns
  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_E = 7'h79;

  typedef enum logic [1:0] {
    S_ONE = 2'd0,
    S_TEN = 2'd1,
    S_HUN = 2'd2
  } dig_st_e;

  localparam logic [7:0] SEG_OFF_AL = 8'hFF;
  localparam logic [2:0] AN_OFF_AL  = 3'b111;
  localparam logic [7:0] SEG_OFF_AH = 8'h00;
  localparam logic [2:0] AN_OFF_AH  = 3'b000;

endpackage

// File: rtl/seg_dec.sv
// BCD digit to active-high 7-segment pattern; anything above 9 shows "E".
module seg_dec
  import seg_pkg::*;
(
  input  logic [3:0] val_i,
  output logic [6:0] pat_o
);

  always_comb begin
    pat_o = SEG_E;
    case (val_i)
      4'd0: pat_o = SEG_0;
      4'd1: pat_o = SEG_1;
      4'd2: pat_o = SEG_2;
      4'd3: pat_o = SEG_3;
      4'd4: pat_o = SEG_4;
      4'd5: pat_o = SEG_5;
      4'd6: pat_o = SEG_6;
      4'd7: pat_o = SEG_7;
      4'd8: pat_o = SEG_8;
      4'd9: pat_o = SEG_9;
      default: pat_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/seg_scan.sv
// Three-digit multiplexed 7-segment driver: captures a BCD result on load,
// scans ones/tens/hundreds with per-slot dead-time and optional zero blanking.
module seg_scan
  import seg_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] one,
  input  logic [3:0] ten,
  input  logic [1:0] hun,
  input  logic       load,
  input  logic       blank_lz,
  output logic [7:0] seg,
  output logic [2:0] an,
  output logic       disp_vld
);

  localparam int          CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_W  = CW'(BLANK_CYC);
  localparam logic [7:0]  SEG_OFF  = SEG_ACTIVE_LOW ? SEG_OFF_AL : SEG_OFF_AH;
  localparam logic [2:0]  AN_OFF   = SEG_ACTIVE_LOW ? AN_OFF_AL  : AN_OFF_AH;

  logic [CW-1:0] cnt_q;
  dig_st_e       state_q;
  logic [3:0]    held_one_q, held_ten_q;
  logic [1:0]    held_hun_q;
  logic          disp_vld_q;
  logic [7:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic [3:0] dec_in;
  logic [6:0] dec_pat;
  logic [2:0] an_oh;
  logic       slot_on;

  // Single decoder shared by all slots; hun==3 is forced out of BCD range.
  always_comb begin
    dec_in  = held_one_q;
    an_oh   = 3'b001;
    slot_on = 1'b1;
    case (state_q)
      S_TEN: begin
        dec_in  = held_ten_q;
        an_oh   = 3'b010;
        slot_on = !(blank_lz && held_hun_q == 2'd0 && held_ten_q == 4'd0);
      end
      S_HUN: begin
        dec_in  = (held_hun_q == 2'd3) ? 4'hF : {2'b00, held_hun_q};
        an_oh   = 3'b100;
        slot_on = !(blank_lz && held_hun_q == 2'd0);
      end
      default: ;
    endcase
  end

  seg_dec u_dec (
    .val_i (dec_in),
    .pat_o (dec_pat)
  );

  always_comb begin
    seg_d = SEG_OFF;
    an_d  = AN_OFF;
    if (disp_vld_q && cnt_q >= BLANK_W && slot_on) begin
      seg_d = SEG_ACTIVE_LOW ? ~{1'b0, dec_pat} : {1'b0, dec_pat};
      an_d  = SEG_ACTIVE_LOW ? ~an_oh : an_oh;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      state_q    <= S_ONE;
      held_one_q <= '0;
      held_ten_q <= '0;
      held_hun_q <= '0;
      disp_vld_q <= 1'b0;
      seg_q      <= SEG_OFF;
      an_q       <= AN_OFF;
    end else begin
      if (cnt_q == CNT_LAST) begin
        cnt_q <= '0;
        case (state_q)
          S_ONE:   state_q <= S_TEN;
          S_TEN:   state_q <= S_HUN;
          default: state_q <= S_ONE;
        endcase
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (load) begin
        held_one_q <= one;
        held_ten_q <= ten;
        held_hun_q <= hun;
        disp_vld_q <= 1'b1;
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg      = seg_q;
  assign an       = an_q;
  assign disp_vld = disp_vld_q;

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan at SCAN_DIV=8, BLANK_CYC=2, active-low outputs.
module tb_seg_scan;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] one = '0, ten = '0;
  logic [1:0] hun = '0;
  logic       load = 1'b0, blank_lz = 1'b0;
  logic [7:0] seg;
  logic [2:0] an;
  logic       disp_vld;

  int total = 0;
  int bad   = 0;

  seg_scan #(.SCAN_DIV(8), .BLANK_CYC(2), .SEG_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .one(one), .ten(ten), .hun(hun),
    .load(load), .blank_lz(blank_lz), .seg(seg), .an(an), .disp_vld(disp_vld)
  );

  always #5 clk = ~clk;

  // Reset for one cycle, release at a falling edge; next posedge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    load  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      total++;
      if (seg !== 8'hFF || an !== 3'b111 || disp_vld !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle edge %0d: got seg=%h an=%b vld=%b want seg=ff an=111 vld=0",
                 n, seg, an, disp_vld);
      end
    end
  endtask

  // Load at edge 1 then check a full frame against hand-computed slot values.
  task automatic frame(input string nm, input logic [3:0] o, input logic [3:0] t,
                       input logic [1:0] h, input logic bl,
                       input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                       input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2);
    logic [7:0] es [3];
    logic [2:0] ea [3];
    int act [3];
    int m, sl;
    es[0] = e0; es[1] = e1; es[2] = e2;
    ea[0] = a0; ea[1] = a1; ea[2] = a2;
    act[0] = 0; act[1] = 0; act[2] = 0;
    do_reset();
    one = o; ten = t; hun = h; blank_lz = bl; load = 1'b1;
    for (int n = 1; n <= 24; n++) begin
      @(negedge clk);
      load = 1'b0;
      m  = n - 1;
      sl = (m / 8) % 3;
      if (an !== 3'b111) act[sl]++;
      total++;
      if ((m % 8) < 2) begin
        if (seg !== 8'hFF || an !== 3'b111) begin
          bad++;
          $display("FAIL %s dead edge %0d: got seg=%h an=%b want seg=ff an=111", nm, n, seg, an);
        end
      end else if (seg !== es[sl] || an !== ea[sl]) begin
        bad++;
        $display("FAIL %s slot%0d edge %0d: got seg=%h an=%b want seg=%h an=%b",
                 nm, sl, n, seg, an, es[sl], ea[sl]);
      end
      if (n == 1) begin
        total++;
        if (disp_vld !== 1'b1) begin
          bad++;
          $display("FAIL %s vld: got %b want 1", nm, disp_vld);
        end
      end
    end
    for (int s = 0; s < 3; s++) begin
      total++;
      if (act[s] != ((ea[s] == 3'b111) ? 0 : 6)) begin
        bad++;
        $display("FAIL %s active_count slot%0d: got %0d want %0d",
                 nm, s, act[s], (ea[s] == 3'b111) ? 0 : 6);
      end
    end
  endtask

  task automatic test_digits();
    frame("digits_123", 4'd3, 4'd2, 2'd1, 1'b0, 8'hB0, 8'hA4, 8'hF9, 3'b110, 3'b101, 3'b011);
  endtask

  task automatic test_blank_lz();
    frame("lz_on_007",  4'd7, 4'd0, 2'd0, 1'b1, 8'hF8, 8'hFF, 8'hFF, 3'b110, 3'b111, 3'b111);
    frame("lz_off_007", 4'd7, 4'd0, 2'd0, 1'b0, 8'hF8, 8'hC0, 8'hC0, 3'b110, 3'b101, 3'b011);
  endtask

  task automatic test_err();
    frame("err_ten", 4'd5, 4'hA, 2'd0, 1'b1, 8'h92, 8'h86, 8'hFF, 3'b110, 3'b101, 3'b111);
    frame("err_hun", 4'd0, 4'd0, 2'd3, 1'b1, 8'hC0, 8'hC0, 8'h86, 3'b110, 3'b101, 3'b011);
  endtask

  task automatic test_midload();
    do_reset();
    one = 4'd3; ten = 4'd2; hun = 2'd1; blank_lz = 1'b0; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (3) @(negedge clk);           // now after edge 4, ones slot active
    one = 4'd5; ten = 4'd5; hun = 2'd2; load = 1'b1;
    @(negedge clk);                      // edge 5 captured the new set
    load = 1'b0;
    total++;
    if (seg !== 8'hB0 || an !== 3'b110) begin
      bad++;
      $display("FAIL midload_edge5: got seg=%h an=%b want seg=b0 an=110", seg, an);
    end
    @(negedge clk);
    total++;
    if (seg !== 8'h92 || an !== 3'b110) begin
      bad++;
      $display("FAIL midload_edge6: got seg=%h an=%b want seg=92 an=110", seg, an);
    end
  endtask

  task automatic test_async_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (seg !== 8'hFF || an !== 3'b111 || disp_vld !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got seg=%h an=%b vld=%b want seg=ff an=111 vld=0",
               seg, an, disp_vld);
    end
    @(negedge clk);
    rst_n = 1'b1;
    one = 4'd5; ten = 4'd5; hun = 2'd2; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    total++;
    if (an !== 3'b111) begin
      bad++;
      $display("FAIL post_reset_edge2: got an=%b want 111", an);
    end
    @(negedge clk);
    total++;
    if (seg !== 8'h92 || an !== 3'b110) begin
      bad++;
      $display("FAIL post_reset_edge3: got seg=%h an=%b want seg=92 an=110", seg, an);
    end
  endtask

  initial begin
    test_reset();
    test_digits();
    test_blank_lz();
    test_err();
    test_midload();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
Name: seg_scan

Overview:
- Downstream display stage of the calculator datapath.
- Captures the BCD result (hundreds/tens/ones) from the binary-to-BCD converter on a load strobe.
- Time-multiplexes the three digits onto one shared 8-bit segment bus (common-anode, active-low), with dead-time between digits to stop ghosting.
- Optionally blanks leading zeros; shows "E" for any out-of-range digit.

Parameters:
SCAN_DIV, 50000, clock cycles per digit slot (>= BLANK_CYC+2)
BLANK_CYC, 4, dead-time cycles at start of each slot with all digits off (>= 1)
SEG_ACTIVE_LOW, 1, 1: segment/anode outputs active-low; 0: active-high

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
one  input  4  BCD ones digit from converter
ten  input  4  BCD tens digit from converter
hun  input  2  BCD hundreds digit from converter (valid range 0..2)
load  input  1  capture strobe; upstream pulses it in the cycle its outputs are valid
blank_lz  input  1  1 = suppress leading zeros
seg  output  8  seg[7]=dp (always off), seg[6:0]=g..a
an  output  3  digit enable; an[0]=ones, an[1]=tens, an[2]=hundreds
disp_vld  output  1  1 once at least one load has been captured since reset

Behaviour:
- Reset (rst_n=0, async): held digits=0; scan counter=0; digit state=S_ONE; disp_vld=0; seg=all off; an=all off. "Off" = 8'hFF / 3'b111 when SEG_ACTIVE_LOW=1, else all zeros.
- Capture: on each rising edge with load=1, held_one/held_ten/held_hun <= one/ten/hun and disp_vld <= 1.
  - load held high re-captures every cycle.
  - load needs no handshake back; the block is always ready.
- Scan counter cnt: 0..SCAN_DIV-1, increments every cycle, wraps to 0.
  - On wrap, digit FSM advances: S_ONE -> S_TEN -> S_HUN -> S_ONE.
  - Frame period = 3*SCAN_DIV cycles.
- Dead-time:
  - While cnt < BLANK_CYC, next seg/an = all off.
  - Otherwise next an = one-hot for the current state; next seg = decode(held digit of that state).
- seg and an are registered from current cnt/state/held values (1-cycle lag).
  - After reset release, the first active an (ones) appears at edge BLANK_CYC+1.
  - It stays active for SCAN_DIV-BLANK_CYC cycles.
- Load latency: value captured at edge k is visible on seg at edge k+1 if that digit is active then.
  - No tearing: seg always reflects one consistent held set.
- disp_vld=0: seg/an forced all off; the counter and FSM still run.
- Leading-zero blanking (blank_lz=1):
  - Hundreds slot is off (an bit inactive) when held_hun==0.
  - Tens slot is off when held_hun==0 and held_ten==0.
  - Ones slot is never blanked; value 0 shows "0".
  - An "E" digit counts as non-zero.
- Decode (active-high gfedcba, inverted when SEG_ACTIVE_LOW=1):
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
  - Any ones/tens value >9, or hun==3, gives "E"=79.
- Simultaneous load and slot switch: the new held values are used by the newly selected digit's first active cycle.
- Reset mid-frame: immediate all-off; scan restarts at S_ONE with cnt=0; held values and disp_vld cleared.

Decomposition:
- Package seg_pkg holds:
  - 7-bit segment constants SEG_0..SEG_9 and SEG_E (active-high);
  - the digit-state encoding S_ONE=2'd0, S_TEN=2'd1, S_HUN=2'd2;
  - the off values.
- One combinational sub-module, seg_dec: 4-bit value in, 7-bit active-high pattern out, "E" for >9.
  - Instantiated once, with a mux on its input.
  - Hundreds input is zero-extended; hun==3 is mapped to 4'hF before decode.

Test Plan (SCAN_DIV=8, BLANK_CYC=2, SEG_ACTIVE_LOW=1):
- Reset, no load -> seg=8'hFF, an=3'b111, disp_vld=0 for 3 full frames (24 cycles).
- load with hun=1, ten=2, one=3, blank_lz=0 -> disp_vld=1 next edge; over one frame, each an slot active 6 of 8 cycles.
  - an=110 gives seg=8'hB0; an=101 gives seg=8'hA4; an=011 gives seg=8'hF9.
  - an=111 for 2 cycles between slots.
- hun=0, ten=0, one=7, blank_lz=1 -> only an=110 ever active with seg=8'hF8; tens/hundreds slots stay 111.
  - Same input with blank_lz=0 -> tens/hundreds show 8'hC0.
- hun=0, ten=4'hA, one=5, blank_lz=1 -> tens shows "E" (8'h86) and is not blanked; hundreds blanked; ones 8'h92.
- load a new value (255 -> 2,5,5) mid-slot while ones is active -> seg changes to 8'h92 exactly one edge after the load edge, with no intermediate pattern.
- Assert rst_n=0 mid-slot asynchronously -> seg/an go all off before the next clock edge; after release, the ones slot is active at edge 3.
